// File: rtl/uart_defs_pkg.sv
// Shared encodings for the UART TX path: FSM states, parity/data-width codes, parity helper.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_MARK
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  function automatic logic [7:0] data_mask(input logic [1:0] bits_code);
    logic [7:0] m;
    case (bits_code)
      DBITS_5: m = 8'h1F;
      DBITS_6: m = 8'h3F;
      DBITS_7: m = 8'h7F;
      DBITS_8: m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] bits_code,
                                       input logic [1:0] par);
    logic ones;
    logic p;
    ones = ^(data & data_mask(bits_code));
    case (par)
      PAR_EVEN: p = ones;
      PAR_ODD:  p = ~ones;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO; read data valid combinationally while not empty.
// A write into a full FIFO is accepted only if a pop happens in the same cycle, else dropped.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_wr;
  logic             w_rd;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_rd       = i_rd_en && !o_empty;
  assign w_wr       = i_wr_en && (!o_full || w_rd);
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= i_wr_en && !w_wr;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-fed framer with baud divider, 5-8 data bits, parity, 1/2 stop, break.
// tx falls one edge after the FIFO becomes non-empty; frames run back-to-back while data is queued.
module uart_tx_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          cfg_break,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          txff_full,
  output logic                          txff_empty,
  output logic [$clog2(FIFO_DEPTH):0]   txff_count,
  output logic                          wr_overflow
);
  import uart_defs::*;

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  tx_state_e        r_state, w_state_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_tx_done, w_done;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_bits;
  logic [1:0]       r_par;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_stop_idx;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [TW-1:0]    r_tick_cnt;

  logic [DIV_W-1:0] w_div_m1;
  logic             w_baud_tick;
  logic             w_tick_wrap;
  logic             w_bit_end;
  logic             w_pop;
  logic             w_shift;
  logic             w_stop_adv;
  logic             w_clr_baud;
  logic             w_can_start;
  logic [2:0]       w_last_idx;
  logic [7:0]       w_rd_data;
  logic             w_empty;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (txff_full),
    .o_empty    (w_empty),
    .o_count    (txff_count),
    .o_overflow (wr_overflow)
  );

  // A divider of 0 behaves as 1; >= keeps the counter bounded if the divider shrinks mid-count.
  assign w_div_m1    = (baud_div == '0) ? '0 : baud_div - 1'b1;
  assign w_baud_tick = (r_baud_cnt >= w_div_m1);
  assign w_tick_wrap = (r_tick_cnt == TW'(OVERSAMPLE - 1));
  assign w_bit_end   = w_baud_tick && w_tick_wrap;
  assign w_last_idx  = 3'(r_bits) + 3'd4;
  assign w_can_start = uart_en && !w_empty && !cfg_break;

  always_ff @(posedge clk) begin
    if (reset || w_clr_baud) begin
      r_baud_cnt <= '0;
      r_tick_cnt <= '0;
    end else if (w_baud_tick) begin
      r_baud_cnt <= '0;
      r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_stop_adv  = 1'b0;
    w_done      = 1'b0;
    w_clr_baud  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (cfg_break) begin
          w_state_nxt = ST_BREAK;
          w_tx_nxt    = 1'b0;
        end else if (w_can_start) begin
          w_pop       = 1'b1;
          w_clr_baud  = 1'b1;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: if (w_bit_end) begin
        w_state_nxt = ST_DATA;
        w_tx_nxt    = r_shift[0];
      end
      ST_DATA: if (w_bit_end) begin
        w_shift = 1'b1;
        if (r_bit_idx == w_last_idx) begin
          if (r_par != PAR_NONE) begin
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_par_bit;
          end else begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_tx_nxt = r_shift[1];
        end
      end
      ST_PARITY: if (w_bit_end) begin
        w_state_nxt = ST_STOP;
        w_tx_nxt    = 1'b1;
      end
      ST_STOP: if (w_bit_end) begin
        if (r_stop2 && !r_stop_idx) begin
          w_stop_adv = 1'b1;
        end else begin
          w_done = 1'b1;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_clr_baud  = 1'b1;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        w_tx_nxt = 1'b0;
        if (!cfg_break) begin
          w_state_nxt = ST_MARK;
          w_tx_nxt    = 1'b1;
          w_clr_baud  = 1'b1;
        end
      end
      ST_MARK: if (w_bit_end) w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_bits     <= '0;
      r_par      <= PAR_NONE;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_tx_done <= w_done;
      if (w_pop) begin
        r_shift    <= w_rd_data;
        r_bits     <= cfg_data_bits;
        r_par      <= cfg_parity;
        r_par_bit  <= calc_parity(w_rd_data, cfg_data_bits, cfg_parity);
        r_stop2    <= cfg_stop2;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (w_shift) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_stop_adv) r_stop_idx <= 1'b1;
    end
  end

  assign tx         = r_tx;
  assign tx_done    = r_tx_done;
  assign tx_busy    = (r_state != ST_IDLE);
  assign txff_empty = w_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: framing, parity, FIFO fill/overflow, break, reset abort.
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_en;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        cfg_break;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
  logic        txff_full;
  logic        txff_empty;
  logic [4:0]  txff_count;
  logic        wr_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.FIFO_DEPTH(16), .DIV_W(16), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_en       (uart_en),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .cfg_break     (cfg_break),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .txff_full     (txff_full),
    .txff_empty    (txff_empty),
    .txff_count    (txff_count),
    .wr_overflow   (wr_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one byte; returns one cycle after the write edge.
  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  // Called just after the start-bit edge; checks every bit mid-period, then tx_done on the end edge.
  task automatic frame(input string tag, input logic [15:0] bits, input int n, input int p);
    step(p / 2);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s bit%0d", tag, k), {31'd0, tx}, {31'd0, bits[k]});
      if (k < n - 1) step(p);
    end
    step(p - p / 2);
    chk($sformatf("%s done", tag), {31'd0, tx_done}, 32'd1);
  endtask

  initial begin
    logic [7:0] d [17];
    logic       seen_done;
    logic       seen_low;

    reset = 1'b1; uart_en = 1'b1; baud_div = 16'd27;
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_break = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00;

    // Reset state
    step(5);
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst empty", {31'd0, txff_empty}, 32'd1);
    chk("rst full", {31'd0, txff_full}, 32'd0);
    chk("rst count", {27'd0, txff_count}, 32'd0);
    chk("rst busy", {31'd0, tx_busy}, 32'd0);
    chk("rst done", {31'd0, tx_done}, 32'd0);
    reset = 1'b0;

    // 8N1, 432 clk/bit, 0x61; start bit on the second edge after the write
    push(8'h61);
    chk("lat count", {27'd0, txff_count}, 32'd1);
    chk("lat tx hi", {31'd0, tx}, 32'd1);
    step(1);
    chk("lat tx lo", {31'd0, tx}, 32'd0);
    chk("lat busy", {31'd0, tx_busy}, 32'd1);
    chk("lat popped", {27'd0, txff_count}, 32'd0);
    frame("8N1 61", 16'b0000_0010_1100_0010, 10, 432);
    chk("8N1 idle tx", {31'd0, tx}, 32'd1);
    chk("8N1 idle busy", {31'd0, tx_busy}, 32'd0);
    step(1);
    chk("8N1 done pulse", {31'd0, tx_done}, 32'd0);

    // 7E2 0x5C; config changed right after start must not affect this frame
    cfg_data_bits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    push(8'h5C);
    step(1);
    cfg_data_bits = 2'b11; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    frame("7E2 5C", 16'b0000_0110_1011_1000, 11, 432);

    // 8O1 0xDA: five ones, parity bit 0
    push(8'hDA);
    step(1);
    frame("8O1 DA", 16'b0000_0101_1011_0100, 11, 432);

    // 5-bit mark parity, 0xE3 -> only 0x03 sent, parity 1
    cfg_data_bits = 2'b00; cfg_parity = 2'b11;
    push(8'hE3);
    step(1);
    frame("5M1 E3", 16'b0000_0000_1100_0110, 8, 432);

    // FIFO fill with uart disabled, overflow on 17th write, then 16 back-to-back frames
    baud_div = 16'd2; cfg_data_bits = 2'b11; cfg_parity = 2'b00; uart_en = 1'b0;
    for (int i = 0; i < 17; i++) d[i] = 8'(i * 37 + 5);
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = d[i];
      step(1);
      if (i == 15) begin
        chk("fill full", {31'd0, txff_full}, 32'd1);
        chk("fill count16", {27'd0, txff_count}, 32'd16);
        chk("fill no ovf", {31'd0, wr_overflow}, 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("ovf pulse", {31'd0, wr_overflow}, 32'd1);
    chk("ovf count", {27'd0, txff_count}, 32'd16);
    chk("ovf tx idle", {31'd0, tx}, 32'd1);
    step(1);
    chk("ovf pulse end", {31'd0, wr_overflow}, 32'd0);
    uart_en = 1'b1;
    step(1);
    chk("b2b first pop", {27'd0, txff_count}, 32'd15);
    for (int j = 0; j < 16; j++) begin
      frame($sformatf("b2b f%0d", j), {6'd0, 1'b1, d[j], 1'b0}, 10, 32);
      if (j < 15) chk($sformatf("b2b gap f%0d", j), {31'd0, tx}, 32'd0);
    end
    chk("b2b end tx", {31'd0, tx}, 32'd1);
    chk("b2b end empty", {31'd0, txff_empty}, 32'd1);

    // Break while a byte is queued, then one mark bit, then the frame
    cfg_break = 1'b1;
    step(1);
    push(8'h55);
    step(1000);
    chk("brk tx", {31'd0, tx}, 32'd0);
    chk("brk busy", {31'd0, tx_busy}, 32'd1);
    chk("brk no pop", {27'd0, txff_count}, 32'd1);
    cfg_break = 1'b0;
    step(1);
    chk("mark rise", {31'd0, tx}, 32'd1);
    step(31);
    chk("mark hold", {31'd0, tx}, 32'd1);
    chk("mark busy", {31'd0, tx_busy}, 32'd1);
    step(1);
    chk("mark idle tx", {31'd0, tx}, 32'd1);
    chk("mark idle busy", {31'd0, tx_busy}, 32'd0);
    chk("mark count", {27'd0, txff_count}, 32'd1);
    step(1);
    chk("post brk start", {31'd0, tx}, 32'd0);
    frame("post brk 55", 16'b0000_0010_1010_1010, 10, 32);

    // Reset in the middle of the third of five queued frames
    uart_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = d[i];
      step(1);
    end
    wr_en = 1'b0;
    chk("q5 count", {27'd0, txff_count}, 32'd5);
    uart_en = 1'b1;
    step(1);
    step(640 + 112);
    chk("mid f3 busy", {31'd0, tx_busy}, 32'd1);
    chk("mid f3 count", {27'd0, txff_count}, 32'd2);
    reset = 1'b1;
    step(1);
    chk("abort tx", {31'd0, tx}, 32'd1);
    chk("abort busy", {31'd0, tx_busy}, 32'd0);
    chk("abort count", {27'd0, txff_count}, 32'd0);
    chk("abort empty", {31'd0, txff_empty}, 32'd1);
    chk("abort done", {31'd0, tx_done}, 32'd0);
    reset = 1'b0;
    seen_done = 1'b0;
    seen_low  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      seen_done |= tx_done;
      seen_low  |= ~tx;
    end
    chk("abort no done", {31'd0, seen_done}, 32'd0);
    chk("abort no tx", {31'd0, seen_low}, 32'd0);

    // Divider 0 runs as 1: 16 clk per bit
    baud_div = 16'd0;
    push(8'hA5);
    step(1);
    frame("div0 A5", 16'b0000_0011_0100_1010, 10, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
